// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start request,
// shifts one byte plus odd parity and stop on device clock falls, and checks the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER         = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int unsigned MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TW   = $clog2(MAXC + 1);
  localparam int unsigned FW   = (FILTER > 1) ? $clog2(FILTER) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  // Line index 0 is the clock, 1 is the data line.
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_filt;
  logic [1:0]    r_filt_d;
  logic [FW-1:0] r_fcnt [2];

  assign w_raw = {ps2_data_in, ps2_clock_in};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_filt   <= '1;
      r_filt_d <= '1;
      for (int unsigned i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_nedge;
  logic [7:0]    r_data;
  logic          r_ack;

  logic w_fall;
  logic w_tmr_expire;
  logic w_in_frame;
  logic w_finish;

  assign w_fall       = r_filt_d[0] & ~r_filt[0];
  assign w_tmr_expire = (r_timer <= TW'(1));
  assign w_in_frame   = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_finish     = (r_state == S_WAIT_IDLE) && (&r_filt);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_nedge      <= '0;
      r_data       <= '0;
      r_ack        <= 1'b0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'b00;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b0;
          busy         <= 1'b0;
          if (send) begin
            r_data       <= tx_data;
            err_code     <= 2'b00;
            r_timer      <= TW'(INHIBIT_CYCLES);
            ps2_clock_oe <= 1'b1;
            busy         <= 1'b1;
            r_state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (w_tmr_expire) begin
            r_timer     <= '0;
            ps2_data_oe <= 1'b1;
            r_state     <= S_REQ;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_REQ: begin
          ps2_clock_oe <= 1'b0;
          r_timer      <= TW'(TIMEOUT_CYCLES);
          r_nedge      <= '0;
          r_ack        <= 1'b0;
          r_state      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_fall) begin
            r_nedge <= r_nedge + 1'b1;
            if (r_nedge < 4'd8) begin
              ps2_data_oe <= ~r_data[r_nedge[2:0]];
            end else if (r_nedge == 4'd8) begin
              ps2_data_oe <= ^r_data;
            end else begin
              ps2_data_oe <= 1'b0;
              r_state     <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (w_fall) begin
            r_nedge <= r_nedge + 1'b1;
            r_ack   <= ~r_filt[1];
            r_state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (w_finish) begin
            busy     <= 1'b0;
            done     <= r_ack;
            error    <= ~r_ack;
            err_code <= r_ack ? 2'b00 : 2'b10;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Frame timeout overrides whatever the state case scheduled above.
      if (w_in_frame) begin
        r_timer <= r_timer - 1'b1;
        if (w_tmr_expire && !w_finish) begin
          r_state      <= S_IDLE;
          ps2_clock_oe <= 1'b0;
          ps2_data_oe  <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
          error        <= 1'b1;
          err_code     <= 2'b01;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the observed bits and status are compared against frames built from the byte.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 1000;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned FLT  = 8;
  localparam int          HALF = 40;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       send = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clock_oe, ps2_data_oe, busy, done, error;
  logic [1:0] err_code;
  wire        ps2_clock_in = dev_clk & ~ps2_clock_oe;
  wire        ps2_data_in  = dev_dat & ~ps2_data_oe;

  int          compared = 0;
  int          mismatched = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int unsigned err_cyc = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER        (FLT)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .send        (send),
    .tx_data     (tx_data),
    .ps2_clock_in(ps2_clock_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (done && error) both_cnt++;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Expected line levels as the device sees them: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic start_send(input logic [7:0] b, output int inh_len, output int rise_idx,
                            output logic busy_first, output int unsigned rel_cyc);
    @(negedge clk);
    send    = 1'b1;
    tx_data = b;
    @(negedge clk);
    send       = 1'b0;
    tx_data    = ~b;
    busy_first = busy;
    inh_len    = 0;
    rise_idx   = -1;
    while (ps2_clock_oe && inh_len < int'(INH) + 50) begin
      if (ps2_data_oe && rise_idx < 0) rise_idx = inh_len;
      inh_len++;
      @(negedge clk);
    end
    rel_cyc = cyc;
  endtask

  task automatic device(input int edges, input logic ack, output logic [10:0] bits);
    bits = '1;
    for (int k = 1; k <= edges; k++) begin
      repeat (HALF) @(negedge clk);
      if (k <= 11) bits[k-1] = ps2_data_in;
      if (k == 11 && ack) begin
        dev_dat = 1'b0;
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic wait_not_busy(input string name, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (busy) begin
      mismatched++;
      $display("FAIL %s_busy_timeout: busy still 1 after %0d cycles, required 0", name, limit);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input logic ack);
    int          inh_len, rise_idx, d0, e0, b0;
    logic        bf;
    int unsigned rel;
    logic [10:0] bits, exp_bits;
    logic [1:0]  exp_code;
    d0 = done_cnt; e0 = err_cnt; b0 = both_cnt;
    exp_bits = frame_of(b);
    exp_code = ack ? 2'b00 : 2'b10;
    start_send(b, inh_len, rise_idx, bf, rel);
    compared++;
    if (bf !== 1'b1) begin
      mismatched++; $display("FAIL %s_busy_on_accept: got %b, required 1", name, bf);
    end
    compared++;
    if (inh_len != int'(INH) + 1) begin
      mismatched++; $display("FAIL %s_clock_low_len: got %0d, required %0d", name, inh_len, INH + 1);
    end
    compared++;
    if (rise_idx != int'(INH)) begin
      mismatched++; $display("FAIL %s_start_bit_cycle: got %0d, required %0d", name, rise_idx, INH);
    end
    device(11, ack, bits);
    compared++;
    if (bits !== exp_bits) begin
      mismatched++; $display("FAIL %s_bits: got %b, required %b", name, bits, exp_bits);
    end
    wait_not_busy(name, 2000);
    compared++;
    if (done_cnt - d0 != (ack ? 1 : 0)) begin
      mismatched++; $display("FAIL %s_done_pulses: got %0d, required %0d", name, done_cnt - d0, ack ? 1 : 0);
    end
    compared++;
    if (err_cnt - e0 != (ack ? 0 : 1)) begin
      mismatched++; $display("FAIL %s_error_pulses: got %0d, required %0d", name, err_cnt - e0, ack ? 0 : 1);
    end
    compared++;
    if (err_code !== exp_code) begin
      mismatched++; $display("FAIL %s_err_code: got %b, required %b", name, err_code, exp_code);
    end
    compared++;
    if (both_cnt != b0) begin
      mismatched++; $display("FAIL %s_done_and_error: got %0d cycles, required 0", name, both_cnt - b0);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({ps2_clock_oe, ps2_data_oe, busy, done, error, err_code} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {ps2_clock_oe, ps2_data_oe, busy, done, error, err_code});
    end
    clrn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_ed();
    run_frame("send_ed", 8'hED, 1'b1);
  endtask

  task automatic test_parity_07();
    logic [10:0] exp;
    exp = frame_of(8'h07);
    compared++;
    if (exp[9] !== 1'b0) begin
      mismatched++; $display("FAIL parity_07_model: got %b, required 0", exp[9]);
    end
    run_frame("parity_07", 8'h07, 1'b1);
  endtask

  task automatic test_zero_byte();
    run_frame("zero_byte", 8'h00, 1'b1);
  endtask

  task automatic test_no_ack();
    run_frame("no_ack", 8'h5A, 1'b0);
  endtask

  task automatic test_timeout();
    int          inh_len, rise_idx, d0, e0;
    logic        bf;
    int unsigned rel;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_send(8'hA3, inh_len, rise_idx, bf, rel);
    device(4, 1'b1, bits);
    wait_not_busy("timeout", int'(TMO) + 200);
    compared++;
    if (err_cnt - e0 != 1 || err_cyc - rel != TMO) begin
      mismatched++;
      $display("FAIL timeout_error_time: got %0d pulses at release+%0d, required 1 at release+%0d",
               err_cnt - e0, err_cyc - rel, TMO);
    end
    compared++;
    if (err_code !== 2'b01) begin
      mismatched++; $display("FAIL timeout_err_code: got %b, required 01", err_code);
    end
    compared++;
    if ({ps2_clock_oe, ps2_data_oe, busy} !== 3'b000 || done_cnt != d0) begin
      mismatched++;
      $display("FAIL timeout_idle: got oe/busy %b done delta %0d, required 000 and 0",
               {ps2_clock_oe, ps2_data_oe, busy}, done_cnt - d0);
    end
  endtask

  task automatic test_send_while_busy();
    int          inh_len, rise_idx, d0;
    logic        bf;
    int unsigned rel;
    logic [10:0] bits;
    d0 = done_cnt;
    start_send(8'h3C, inh_len, rise_idx, bf, rel);
    fork
      device(11, 1'b1, bits);
      begin
        repeat (300) @(negedge clk);
        send    = 1'b1;
        tx_data = 8'hC5;
        @(negedge clk);
        send = 1'b0;
      end
    join
    wait_not_busy("send_busy", 2000);
    compared++;
    if (bits !== frame_of(8'h3C)) begin
      mismatched++; $display("FAIL send_busy_bits: got %b, required %b", bits, frame_of(8'h3C));
    end
    compared++;
    if (done_cnt - d0 != 1) begin
      mismatched++; $display("FAIL send_busy_done: got %0d, required 1", done_cnt - d0);
    end
    repeat (20) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL send_busy_no_queue: busy got %b, required 0", busy);
    end
  endtask

  task automatic test_reset_midframe();
    int          inh_len, rise_idx, d0, e0;
    logic        bf;
    int unsigned rel;
    logic [10:0] bits;
    d0 = done_cnt; e0 = err_cnt;
    start_send(8'h2A, inh_len, rise_idx, bf, rel);
    device(5, 1'b1, bits);
    compared++;
    if (ps2_data_oe !== 1'b1) begin
      mismatched++; $display("FAIL midframe_bit4: data_oe got %b, required 1", ps2_data_oe);
    end
    @(posedge clk);
    #2;
    clrn = 1'b0;
    #1;
    compared++;
    if ({ps2_clock_oe, ps2_data_oe, busy} !== 3'b000) begin
      mismatched++;
      $display("FAIL midframe_async_release: got %b, required 000", {ps2_clock_oe, ps2_data_oe, busy});
    end
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (200) @(negedge clk);
    compared++;
    if (done_cnt != d0 || err_cnt != e0 || err_code !== 2'b00) begin
      mismatched++;
      $display("FAIL midframe_no_pulse: got done %0d error %0d code %b, required 0 0 00",
               done_cnt - d0, err_cnt - e0, err_code);
    end
  endtask

  task automatic test_after_reset();
    run_frame("after_reset_f4", 8'hF4, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       ack;
    for (int i = 0; i < 4; i++) begin
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("random%0d_%02h", i, b), b, ack);
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity_07();
    test_zero_byte();
    test_no_ack();
    test_timeout();
    test_send_while_busy();
    test_reset_midframe();
    test_after_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the send side of the PS/2 link whose receive side already feeds key and message bytes into the cipher front end. It takes one byte, such as a keyboard LED command (0xED) or its argument byte, and runs the full host-request frame. It drives the shared open-collector clock and data lines through low-side enables, times the inhibit period, and checks the device acknowledge. The top level gates `ps2_clock`/`ps2_data` with the two `*_oe` outputs.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-low inhibit length in cycles (100 us at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum cycles from clock release to the 11th device falling edge (15 ms).
- `FILTER`, default 8: consecutive equal synchronized samples required before a filtered line level changes.
- `clk`, in, 1: system clock.
- `clrn`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `send`, in, 1: request; sampled only in IDLE.
- `tx_data`, in, 8: byte to send; latched on accept.
- `ps2_clock_in`, in, 1: raw PS/2 clock line.
- `ps2_data_in`, in, 1: raw PS/2 data line.
- `ps2_clock_oe`, out, 1: 1 pulls the clock line low.
- `ps2_data_oe`, out, 1: 1 pulls the data line low.
- `busy`, out, 1: 1 in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a frame completes with ACK.
- `error`, out, 1: one-cycle pulse on failure.
- `err_code`, out, 2: held until the next accept. 00 none, 01 timeout, 10 no ACK.

## Operation
- Input conditioning:
  - Each line passes through a 2-FF synchronizer, then a FILTER-sample stability filter.
  - A device falling edge is filtered clock going 1→0.
  - Filtered levels reset to 1.
- States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
- IDLE:
  - All `oe` = 0.
  - `send`=1 latches `tx_data`, clears `err_code`, loads the timer with INHIBIT_CYCLES, and goes to INHIBIT.
- INHIBIT:
  - `ps2_clock_oe`=1, `ps2_data_oe`=0.
  - The timer decrements each cycle; at 0 go to REQ.
- REQ:
  - Exactly 1 cycle with `ps2_clock_oe`=1 and `ps2_data_oe`=1 (start bit).
  - Then go to SHIFT, load the timer with TIMEOUT_CYCLES, and set edge count n=0.
- SHIFT:
  - `ps2_clock_oe`=0. `ps2_data_oe` holds the current bit inverted.
  - On each detected falling edge, n increments and the driven bit changes:
    - n=1..8: `ps2_data_oe` = ~data[n-1] (LSB first).
    - n=9: `ps2_data_oe` = ~parity, where parity = ~^data (odd parity).
    - n=10: `ps2_data_oe`=0 (stop bit, line released).
  - After the 10th edge go to ACK.
- ACK:
  - On the 11th falling edge, sample filtered data; 0 means ACK.
  - Then go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait until filtered clock and data are both 1, then go to IDLE.
  - Pulse `done` if ACK was seen; otherwise pulse `error` with `err_code`=10.
- Timeout:
  - The timer decrements in SHIFT, ACK and WAIT_IDLE.
  - Reaching 0 before the return to IDLE: all `oe`=0, `error` pulse, `err_code`=01, go to IDLE.
- `send` while busy is ignored; there is no queue.
- `tx_data` changes after accept have no effect on the frame in flight.

## Timing
- Reset (`clrn`=0, asynchronous):
  - State IDLE; `ps2_clock_oe`, `ps2_data_oe`, `busy`, `done`, `error` = 0; `err_code`=00.
  - Reset mid-frame releases both lines immediately. No pulse is generated.
- Accept:
  - Edge k with IDLE and `send`=1 gives `busy`=1 and `ps2_clock_oe`=1 from cycle k+1.
  - `ps2_clock_oe` stays 1 for INHIBIT_CYCLES+1 cycles (INHIBIT plus REQ).
  - `ps2_data_oe` rises on the last of these cycles.
- Edge response:
  - A raw clock fall reaches detection after 2+FILTER cycles.
  - `ps2_data_oe` updates on the cycle after detection.
  - Total: at most FILTER+3 cycles from raw edge to new bit. This is well within the device's half clock period (≥30 us).
- `done`/`error` assert in the same cycle that `busy` returns to 0.
- `done` and `error` are never both 1.
- Timer width: ceil(log2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)) bits.
- Edge counter: 4 bits; never exceeds 11.

## Test plan
- Send 0xED (six ones, parity bit 1); device model clocks at 12.5 kHz and ACKs. Required:
  - `ps2_clock_oe` low-drive for 5001 cycles.
  - Bit sequence seen by the device: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done` single pulse; `err_code`=00.
- Send 0x07 (three ones, parity 0): `ps2_data_oe`=1 during the parity bit; `done` pulse.
- Send 0x00: all data bits driven 0, parity 1, stop 1; `done` pulse.
- Device leaves data high on the 11th edge: `error` pulse, `err_code`=10, `done` never asserts.
- TIMEOUT_CYCLES=2000 and the device stops after 4 edges: `error` at clock-release+2000, `err_code`=01, both `oe`=0, `busy`=0.
- Other control behaviour:
  - `send` pulsed mid-frame with a different byte: ignored; the original byte is completed.
  - `clrn` asserted at n=5: both `oe` drop asynchronously; no `done`/`error`.
  - After reset release, a new send of 0xF4 completes normally.
